// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int          INST_ADDR_W = 32;
  localparam int          INST_DATA_W = 32;
  localparam logic [31:0] INS_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] addr;
    logic [INST_DATA_W-1:0] data;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_W-1:0] next_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Synchronous FIFO with combinational head read; push and pop may coincide at any occupancy.
module ifu_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order memory requests, buffers
// responses and hands one instruction per cycle to IF/ID, squashing stale data on jumps.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        ins_valid_o,
  input  logic        ins_ready_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_addr_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t       state, state_n;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic         req_q;
  logic [CW-1:0] outstanding, buf_count, discard, discard_jump;
  logic [CW:0]  credit_sum;
  logic         credit_ok, fresh_req, gnt_ok, push, pop;
  logic [31:0]  aq_head;
  fetch_entry_t buf_head, buf_wdata;

  // A pop this cycle frees a slot, which keeps 1-cycle memory at full throughput.
  assign credit_sum = {1'b0, outstanding} + {1'b0, buf_count} - (CW+1)'(pop);
  assign credit_ok  = credit_sum < (CW+1)'(DEPTH);

  assign mem_req_o  = req_q | ((state == S_RUN) & ~jump_flag_i & credit_ok);
  assign mem_addr_o = req_q ? req_addr : pc;
  assign fresh_req  = mem_req_o & ~req_q;
  assign gnt_ok     = mem_req_o & mem_gnt_i;

  // Every in-flight response becomes stale on a jump, including a request still awaiting gnt.
  assign discard_jump = outstanding - CW'(mem_rvalid_i) + CW'(req_q);

  assign push        = mem_rvalid_i & (discard == '0) & ~jump_flag_i;
  assign ins_valid_o = (buf_count != '0) & ~jump_flag_i;
  assign pop         = ins_valid_o & ins_ready_i & ~hold_flag_i;
  assign ins_o       = ins_valid_o ? buf_head.data : INS_NOP;
  assign ins_addr_o  = ins_valid_o ? buf_head.addr : RESET_ADDR;
  assign buf_wdata   = '{addr: aq_head, data: mem_rdata_i};

  always_comb begin
    state_n = state;
    if (jump_flag_i) begin
      state_n = (discard_jump != '0) ? S_DRAIN : S_RUN;
    end else begin
      case (state)
        S_IDLE:  state_n = S_RUN;
        S_DRAIN: if (mem_rvalid_i && discard == CW'(1)) state_n = S_RUN;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_ADDR;
      req_q   <= 1'b0;
      discard <= '0;
    end else begin
      state <= state_n;
      if (jump_flag_i)    pc <= jump_addr_i;
      else if (fresh_req) pc <= next_pc(pc);
      if (gnt_ok)         req_q <= 1'b0;
      else if (fresh_req) req_q <= 1'b1;
      if (jump_flag_i)                          discard <= discard_jump;
      else if (mem_rvalid_i && discard != '0)   discard <= discard - CW'(1);
    end
  end

  // Address of a request left waiting for gnt; held stable on the bus until accepted.
  always_ff @(posedge clk) begin
    if (fresh_req && !mem_gnt_i) req_addr <= pc;
  end

  // In-flight address queue: occupancy is the outstanding request count.
  ifu_fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_addr_q (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (gnt_ok),
    .wdata (mem_addr_o),
    .pop   (mem_rvalid_i),
    .rdata (aq_head),
    .count (outstanding)
  );

  ifu_fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fetch_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (jump_flag_i),
    .push  (push),
    .wdata (buf_wdata),
    .pop   (pop),
    .rdata (buf_head),
    .count (buf_count)
  );

  a_rvalid_in_flight: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid_i && outstanding == '0));

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: memory responder, expected instruction stream and scoreboard monitor.
module tb_ifu_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        ins_valid_o;
  logic        ins_ready_i;
  logic [31:0] ins_o;
  logic [31:0] ins_addr_o;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .ins_valid_o  (ins_valid_o),
    .ins_ready_i  (ins_ready_i),
    .ins_o        (ins_o),
    .ins_addr_o   (ins_addr_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;
  int tests = 0, fails = 0, cyc = 0, delivered = 0;
  int p_gnt, p_ready, p_hold, p_jump, p_rv, max_lat;
  bit mon_en = 0, chk_first = 0, prev_wait = 0;
  logic [31:0] prev_addr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] a);
    exp_q.delete();
    exp_tail = a;
    refill();
  endtask

  // One bus cycle: drive control and memory response at negedge, grant after req settles.
  task automatic step();
    @(negedge clk);
    cyc++;
    jump_flag_i = ($urandom_range(99) < p_jump);
    if (jump_flag_i) begin
      jump_addr_i = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(255)) << 2);
      restart_stream(jump_addr_i);
    end
    hold_flag_i  = ($urandom_range(99) < p_hold);
    ins_ready_i  = ($urandom_range(99) < p_ready);
    mem_rvalid_i = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc && $urandom_range(99) < p_rv) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = word_of(rsp_q[0].addr);
      void'(rsp_q.pop_front());
    end
    #1;
    if (chk_first) begin
      check("first_req", 32'(mem_req_o), 32'd1);
      check("first_req_addr", mem_addr_o, 32'h0);
      chk_first = 0;
    end
    if (prev_wait) begin
      check("req_held", 32'(mem_req_o), 32'd1);
      check("addr_held", mem_addr_o, prev_addr);
    end
    mem_gnt_i = mem_req_o && ($urandom_range(99) < p_gnt);
    if (mem_req_o && mem_gnt_i)
      rsp_q.push_back('{mem_addr_o, cyc + 1 + int'($urandom_range(max_lat))});
    prev_wait = mem_req_o && !mem_gnt_i;
    prev_addr = mem_addr_o;
    check("credit", 32'(rsp_q.size() <= DEPTH), 32'd1);
    refill();
  endtask

  // Scoreboard monitor, sampling just before each rising edge.
  bit          pv = 0, pfire = 0;
  logic [31:0] paddr, pins;
  always @(negedge clk) begin
    logic fire;
    logic [31:0] e;
    #4;
    if (!mon_en || rst) begin
      pv = 0;
    end else begin
      fire = ins_valid_o && ins_ready_i && !hold_flag_i;
      if (jump_flag_i) check("jump_kills_valid", 32'(ins_valid_o), 32'd0);
      if (!ins_valid_o) begin
        check("idle_ins", ins_o, NOP);
        check("idle_addr", ins_addr_o, 32'h0);
      end
      if (pv && !pfire && !jump_flag_i) begin
        check("stall_valid", 32'(ins_valid_o), 32'd1);
        check("stall_addr", ins_addr_o, paddr);
        check("stall_ins", ins_o, pins);
      end
      if (fire) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ins", ins_addr_o, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("ins_addr", ins_addr_o, e);
          check("ins_data", ins_o, word_of(e));
        end
        delivered++;
      end
      pv = ins_valid_o; pfire = fire; paddr = ins_addr_o; pins = ins_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(mem_req_o), 32'd0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    check({tag, "_valid"}, 32'(ins_valid_o), 32'd0);
    check({tag, "_ins"}, ins_o, NOP);
    check({tag, "_ins_addr"}, ins_addr_o, 32'h0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; jump_flag_i = 0; jump_addr_i = '0; hold_flag_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; ins_ready_i = 0;
    repeat (2) @(negedge clk);
    #4 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    restart_stream(32'h0);
    #4 check("idle_no_req", 32'(mem_req_o), 32'd0);
    mon_en = 1; chk_first = 1;

    // Streaming at full rate with single-cycle memory
    p_gnt = 100; p_ready = 100; p_hold = 0; p_jump = 0; p_rv = 100; max_lat = 0;
    repeat (10) step();
    d0 = delivered;
    repeat (20) step();
    check("throughput", 32'(delivered - d0), 32'd20);

    // Backpressure, then resume
    p_ready = 0;  repeat (5) step();
    p_ready = 100; repeat (10) step();

    // Hold, then resume
    p_hold = 100; repeat (3) step();
    p_hold = 0;   repeat (8) step();

    // Randomized traffic with jumps, stalls and variable latency
    p_gnt = 60; p_ready = 70; p_hold = 15; p_jump = 4; p_rv = 70; max_lat = 3;
    repeat (3000) step();
    p_jump = 20; p_gnt = 40;
    repeat (600) step();

    // Let outstanding responses return without issuing new grants
    p_jump = 0; p_gnt = 0; p_rv = 100; p_ready = 100; p_hold = 0;
    repeat (40) step();
    check("drained", 32'(rsp_q.size()), 32'd0);
    check("progress", 32'(delivered > 500), 32'd1);

    // Reset mid-operation clears everything
    @(negedge clk);
    rst = 1'b1; jump_flag_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    rsp_q.delete(); prev_wait = 0;
    @(negedge clk);
    #4 check_reset_outputs("rereset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
